// File: rtl/gpu_xform_pkg.sv
// Shared definitions for the vertex transform path: axis encoding, the
// elaboration-time sine table generator and the output clamp helper.
package gpu_xform_pkg;

  localparam logic [1:0] AXIS_X   = 2'd0;
  localparam logic [1:0] AXIS_Y   = 2'd1;
  localparam logic [1:0] AXIS_Z   = 2'd2;
  localparam logic [1:0] AXIS_BYP = 2'd3;

  // Fixed-point scale used while evaluating the sine series.
  localparam int TRIG_SHIFT = 32'sd28;
  // pi/2 scaled by 2^TRIG_SHIFT.
  localparam longint HALF_PI_Q = 64'sd421657428;

  // Quarter-wave sine entry: round(sin(idx * 2pi / 2^ang_w) * 2^frac) for
  // idx in 0 .. 2^(ang_w-2). Evaluated only at elaboration with an integer
  // Taylor series so no real arithmetic reaches synthesis.
  function automatic int trig_q(input int idx, input int ang_w, input int frac);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (HALF_PI_Q * longint'(idx)) / longint'(32'sd1 <<< (ang_w - 32'sd2));
    x2   = (x * x) >>> TRIG_SHIFT;
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x2) >>> TRIG_SHIFT;
      term = term / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
      if ((n % 32'sd2) == 32'sd1) begin
        acc = acc - term;
      end else begin
        acc = acc + term;
      end
    end
    return int'(((acc <<< frac) + (64'sd1 <<< (TRIG_SHIFT - 32'sd1))) >>> TRIG_SHIFT);
  endfunction

  // Clamp v into the signed range of a w-bit value; hit reports clamping.
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                   input int w,
                                                   output logic hit);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'sd1));
    if (v > hi) begin
      hit       = 1'b1;
      sat_clamp = hi;
    end else if (v < lo) begin
      hit       = 1'b1;
      sat_clamp = lo;
    end else begin
      hit       = 1'b0;
      sat_clamp = v;
    end
  endfunction

endpackage

// File: rtl/trig_rom.sv
// Registered sin/cos lookup. Only a quarter wave is stored; the other
// quadrants are produced by mirroring the index and negating the value.
// cos(a) is read as sin(a + quarter turn).
module trig_rom
  import gpu_xform_pkg::*;
#(
  parameter int ANG_W = 6,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ANG_W-1:0]        angle,
  output logic signed [FRAC+1:0]  sin_q,
  output logic signed [FRAC+1:0]  cos_q
);

  localparam int QN = 32'sd1 <<< (ANG_W - 2);
  localparam int TW = FRAC + 2;

  logic signed [TW-1:0] qtab [0:QN];

  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam int VAL = trig_q(g, ANG_W, FRAC);
    assign qtab[g] = TW'(VAL);
  end

  logic [ANG_W-1:0]    cidx;
  logic [ANG_W-2:0]    spos;
  logic [ANG_W-2:0]    smir;
  logic [ANG_W-2:0]    cpos;
  logic [ANG_W-2:0]    cmir;
  logic signed [TW-1:0] sin_d;
  logic signed [TW-1:0] cos_d;

  // Fold both the sine and cosine angle into the stored quarter wave.
  always_comb begin
    cidx  = angle + ANG_W'(QN);
    spos  = {1'b0, angle[ANG_W-3:0]};
    smir  = (ANG_W-1)'(QN) - spos;
    cpos  = {1'b0, cidx[ANG_W-3:0]};
    cmir  = (ANG_W-1)'(QN) - cpos;
    sin_d = '0;
    cos_d = '0;
    case (angle[ANG_W-1:ANG_W-2])
      2'd0:    sin_d = qtab[spos];
      2'd1:    sin_d = qtab[smir];
      2'd2:    sin_d = -qtab[spos];
      2'd3:    sin_d = -qtab[smir];
      default: sin_d = '0;
    endcase
    case (cidx[ANG_W-1:ANG_W-2])
      2'd0:    cos_d = qtab[cpos];
      2'd1:    cos_d = qtab[cmir];
      2'd2:    cos_d = -qtab[cpos];
      2'd3:    cos_d = -qtab[cmir];
      default: cos_d = '0;
    endcase
  end

  // Table output register; part of the first pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (en) begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

endmodule

// File: rtl/vertex_rotate_pipe.sv
// Three-stage vertex rotate + translate with a global-stall valid/ready
// stream. S1: operands and trig, S2: six products, S3: sum/round/clamp.
module vertex_rotate_pipe
  import gpu_xform_pkg::*;
#(
  parameter int W     = 10,
  parameter int FRAC  = 8,
  parameter int ANG_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_axis,
  input  logic [ANG_W-1:0]     in_angle,
  input  logic signed [W-1:0]  in_a1,
  input  logic signed [W-1:0]  in_a2,
  input  logic signed [W-1:0]  in_a3,
  input  logic signed [W-1:0]  in_t1,
  input  logic signed [W-1:0]  in_t2,
  input  logic signed [W-1:0]  in_t3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_o1,
  output logic signed [W-1:0]  out_o2,
  output logic signed [W-1:0]  out_o3,
  output logic                 out_sat
);

  localparam int TW = FRAC + 2;
  localparam int PW = W + FRAC + 2;
  localparam int SW = W + FRAC + 4;
  localparam logic signed [TW-1:0] ONE  = TW'(32'sd1 <<< FRAC);
  localparam logic signed [SW-1:0] HALF = SW'(32'sd1 <<< (FRAC - 1));

  logic en;

  // Stage 1 state
  logic                s1_valid;
  logic [1:0]          s1_axis;
  logic signed [W-1:0] s1_a [0:2];
  logic signed [W-1:0] s1_t [0:2];
  logic signed [TW-1:0] s1_sin;
  logic signed [TW-1:0] s1_cos;

  // Stage 2 state
  logic                s2_valid;
  logic signed [PW-1:0] s2_p [0:5];
  logic signed [W-1:0]  s2_t [0:2];

  // Combinational stage results
  logic signed [TW-1:0] coef [0:5];
  logic signed [W-1:0]  opnd [0:5];
  logic signed [W-1:0]  o_d  [0:2];
  logic                 sat_d;
  logic signed [TW-1:0] nsin;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  trig_rom #(
    .ANG_W (ANG_W),
    .FRAC  (FRAC)
  ) u_trig (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .angle (in_angle),
    .sin_q (s1_sin),
    .cos_q (s1_cos)
  );

  // S1: capture operands, axis and valid alongside the trig lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_axis  <= AXIS_X;
      for (int k = 0; k < 3; k++) begin
        s1_a[k] <= '0;
        s1_t[k] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      s1_axis  <= in_axis;
      s1_a[0]  <= in_a1;
      s1_a[1]  <= in_a2;
      s1_a[2]  <= in_a3;
      s1_t[0]  <= in_t1;
      s1_t[1]  <= in_t2;
      s1_t[2]  <= in_t3;
    end
  end

  // Axis mux: output k is coef[2k]*opnd[2k] + coef[2k+1]*opnd[2k+1].
  // Pass-through components use coefficient 1.0 so they land as a<<FRAC.
  always_comb begin
    nsin = -s1_sin;
    for (int k = 0; k < 6; k++) begin
      coef[k] = '0;
      opnd[k] = '0;
    end
    case (s1_axis)
      AXIS_X: begin
        coef[0] = ONE;    opnd[0] = s1_a[0];
        coef[2] = s1_cos; opnd[2] = s1_a[1];
        coef[3] = nsin;   opnd[3] = s1_a[2];
        coef[4] = s1_sin; opnd[4] = s1_a[1];
        coef[5] = s1_cos; opnd[5] = s1_a[2];
      end
      AXIS_Y: begin
        coef[0] = s1_cos; opnd[0] = s1_a[0];
        coef[1] = s1_sin; opnd[1] = s1_a[2];
        coef[2] = ONE;    opnd[2] = s1_a[1];
        coef[4] = nsin;   opnd[4] = s1_a[0];
        coef[5] = s1_cos; opnd[5] = s1_a[2];
      end
      AXIS_Z: begin
        coef[0] = s1_cos; opnd[0] = s1_a[0];
        coef[1] = nsin;   opnd[1] = s1_a[1];
        coef[2] = s1_sin; opnd[2] = s1_a[0];
        coef[3] = s1_cos; opnd[3] = s1_a[1];
        coef[4] = ONE;    opnd[4] = s1_a[2];
      end
      AXIS_BYP: begin
        coef[0] = ONE;    opnd[0] = s1_a[0];
        coef[2] = ONE;    opnd[2] = s1_a[1];
        coef[4] = ONE;    opnd[4] = s1_a[2];
      end
      default: begin
        coef[0] = ONE;    opnd[0] = s1_a[0];
        coef[2] = ONE;    opnd[2] = s1_a[1];
        coef[4] = ONE;    opnd[4] = s1_a[2];
      end
    endcase
  end

  // S2: register full-precision products and carry translation forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        s2_p[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        s2_t[k] <= '0;
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      for (int k = 0; k < 6; k++) begin
        s2_p[k] <= PW'(coef[k]) * PW'(opnd[k]);
      end
      for (int k = 0; k < 3; k++) begin
        s2_t[k] <= s1_t[k];
      end
    end
  end

  // Sum, round half toward +inf, then clamp each component to W bits.
  always_comb begin
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rnd;
    logic                 hit;
    sum   = '0;
    rnd   = '0;
    hit   = 1'b0;
    sat_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum    = SW'(s2_p[2*k]) + SW'(s2_p[2*k+1]) + (SW'(s2_t[k]) <<< FRAC);
      rnd    = (sum + HALF) >>> FRAC;
      o_d[k] = W'(sat_clamp(32'(rnd), W, hit));
      sat_d  = sat_d | hit;
    end
  end

  // S3: output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_o1    <= '0;
      out_o2    <= '0;
      out_o3    <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_o1    <= o_d[0];
      out_o2    <= o_d[1];
      out_o3    <= o_d[2];
      out_sat   <= sat_d;
    end
  end

endmodule

// File: tb/tb_vertex_rotate_pipe.sv
// Directed and streamed checks for vertex_rotate_pipe.
module tb_vertex_rotate_pipe;

  localparam int W     = 10;
  localparam int FRAC  = 8;
  localparam int ANG_W = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_axis;
  logic [ANG_W-1:0]    in_angle;
  logic signed [W-1:0] in_a1, in_a2, in_a3;
  logic signed [W-1:0] in_t1, in_t2, in_t3;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_o1, out_o2, out_o3;
  logic                out_sat;

  int total = 0;
  int bad   = 0;

  vertex_rotate_pipe #(.W(W), .FRAC(FRAC), .ANG_W(ANG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_axis   (in_axis),
    .in_angle  (in_angle),
    .in_a1     (in_a1),
    .in_a2     (in_a2),
    .in_a3     (in_a3),
    .in_t1     (in_t1),
    .in_t2     (in_t2),
    .in_t3     (in_t3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_o1    (out_o1),
    .out_o2    (out_o2),
    .out_o3    (out_o3),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  function automatic int clampw(input int v, inout int sat);
    if (v > 511) begin sat = 1; return 511; end
    else if (v < -512) begin sat = 1; return -512; end
    else return v;
  endfunction

  // Reference transform built from first principles (real trig, integer sums).
  function automatic void model(input int axis, input int angle,
                                input int a1, input int a2, input int a3,
                                input int t1, input int t2, input int t3,
                                output int o1, output int o2, output int o3,
                                output int sat);
    real th;
    int s, c, p1, p2, p3;
    th = real'(angle) * 2.0 * 3.14159265358979 / 64.0;
    s  = rnd_real($sin(th) * 256.0);
    c  = rnd_real($cos(th) * 256.0);
    case (axis)
      0: begin p1 = a1 * 256;      p2 = c * a2 - s * a3; p3 = s * a2 + c * a3; end
      1: begin p1 = c * a1 + s * a3; p2 = a2 * 256;      p3 = -s * a1 + c * a3; end
      2: begin p1 = c * a1 - s * a2; p2 = s * a1 + c * a2; p3 = a3 * 256; end
      default: begin p1 = a1 * 256; p2 = a2 * 256; p3 = a3 * 256; end
    endcase
    sat = 0;
    o1 = clampw((p1 + t1 * 256 + 128) >>> 8, sat);
    o2 = clampw((p2 + t2 * 256 + 128) >>> 8, sat);
    o3 = clampw((p3 + t3 * 256 + 128) >>> 8, sat);
  endfunction

  task automatic set_in(input int axis, input int angle,
                        input int a1, input int a2, input int a3,
                        input int t1, input int t2, input int t3);
    in_axis  = 2'(axis);
    in_angle = ANG_W'(angle);
    in_a1 = W'(a1); in_a2 = W'(a2); in_a3 = W'(a3);
    in_t1 = W'(t1); in_t2 = W'(t2); in_t3 = W'(t3);
  endtask

  // Called just after a rising edge with an empty pipeline.
  task automatic run_vec(input string tag, input int axis, input int angle,
                         input int a1, input int a2, input int a3,
                         input int t1, input int t2, input int t3,
                         input int e1, input int e2, input int e3, input int es);
    set_in(axis, angle, a1, a2, a3, t1, t2, t3);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_c1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    check({tag, "_valid_c2"}, int'(out_valid), 0);
    @(posedge clk); #1;
    check({tag, "_valid_c3"}, int'(out_valid), 1);
    check({tag, "_o1"}, int'(out_o1), e1);
    check({tag, "_o2"}, int'(out_o2), e2);
    check({tag, "_o3"}, int'(out_o3), e3);
    check({tag, "_sat"}, int'(out_sat), es);
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_q[$];
    int sent, got, cyc, h1, h2, h3, hs;
    int ax, an, a1, a2, a3, t1, t2, t3, e1, e2, e3, es;
    bit pending, stall_prev, acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_o1", int'(out_o1), 0);
    check("rst_o2", int'(out_o2), 0);
    check("rst_o3", int'(out_o3), 0);
    check("rst_sat", int'(out_sat), 0);
    @(posedge clk); #1;

    run_vec("y90",  1, 16, 100, 5, -20,   0, 0, 0,    -20, 5, -100, 0);
    run_vec("x45",  0,  8,   0, 100, 0,   3, 0, -1,     3, 71, 70,  0);
    run_vec("byp",  3, 21, 500, -500, 0, 100, -100, 7, 511, -512, 7, 1);
    run_vec("z180", 2, 32, -512, 10, 1,   0, 0, 0,    511, -10, 1,  1);
    run_vec("wrap", 2, 63, 100, 0, 0,     0, 0, 0,    100, -10, 0,  0);

    // Random stream with pseudo-random backpressure.
    sent = 0; got = 0; cyc = 0; pending = 1'b0; stall_prev = 1'b0;
    h1 = 0; h2 = 0; h3 = 0; hs = 0;
    while ((sent < 20 || exp_q.size() != 0) && cyc < 600) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (!pending && sent < 20 && $urandom_range(0, 3) != 0) begin
        ax = $urandom_range(0, 3); an = $urandom_range(0, 63);
        a1 = $urandom_range(0, 1023) - 512; a2 = $urandom_range(0, 1023) - 512;
        a3 = $urandom_range(0, 1023) - 512; t1 = $urandom_range(0, 1023) - 512;
        t2 = $urandom_range(0, 1023) - 512; t3 = $urandom_range(0, 1023) - 512;
        set_in(ax, an, a1, a2, a3, t1, t2, t3);
        in_valid = 1'b1;
        pending  = 1'b1;
      end
      @(negedge clk);
      check("stream_in_ready", int'(in_ready), int'(!out_valid || out_ready));
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_o1", int'(out_o1), h1);
        check("hold_o2", int'(out_o2), h2);
        check("hold_o3", int'(out_o3), h3);
        check("hold_sat", int'(out_sat), hs);
      end
      if (out_valid && out_ready) begin
        got++;
        if (exp_q.size() < 4) begin
          check("stream_extra_output", 1, 0);
        end else begin
          check("stream_o1", int'(out_o1), exp_q.pop_front());
          check("stream_o2", int'(out_o2), exp_q.pop_front());
          check("stream_o3", int'(out_o3), exp_q.pop_front());
          check("stream_sat", int'(out_sat), exp_q.pop_front());
        end
      end
      acc = in_valid && in_ready;
      stall_prev = out_valid && !out_ready;
      h1 = int'(out_o1); h2 = int'(out_o2); h3 = int'(out_o3); hs = int'(out_sat);
      @(posedge clk); #1;
      if (acc) begin
        model(ax, an, a1, a2, a3, t1, t2, t3, e1, e2, e3, es);
        exp_q.push_back(e1); exp_q.push_back(e2);
        exp_q.push_back(e3); exp_q.push_back(es);
        sent++;
        pending  = 1'b0;
        in_valid = 1'b0;
      end
      cyc++;
    end
    check("stream_in_time", int'(cyc < 600), 1);
    check("stream_count", got, 20);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Flush by reset: three accepted vertices must never emerge.
    for (int i = 0; i < 3; i++) begin
      set_in(3, 0, 5 + i, 6, 7, 0, 0, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("flush_pre_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("flush_valid", int'(out_valid), 0);
    check("flush_o1", int'(out_o1), 0);
    check("flush_o2", int'(out_o2), 0);
    check("flush_o3", int'(out_o3), 0);
    check("flush_sat", int'(out_sat), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_no_output", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    run_vec("post_rst", 1, 16, 100, 5, -20, 0, 0, 0, -20, 5, -100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vertex_rotate_pipe.md
# vertex_rotate_pipe

Pipelined, parametrised vertex transform stage for the GPU geometry path. It rotates a signed 3-component vertex about a selectable axis (X, Y, Z or bypass) by a table-driven angle, then adds a translation. The result is rounded and saturated back to coordinate width. It sits between vertex fetch and projection, uses a valid/ready stream on both sides, and replaces the fixed 45°-step, Y-axis-only, unregistered transform with a 3-stage pipeline that supports backpressure.

## Interface
- `W`, 10: coordinate and translation width, signed.
- `FRAC`, 8: fraction bits of sin/cos values. Trig values are signed, FRAC+2 bits wide, so +1.0 is exactly representable.
- `ANG_W`, 6: angle width. One LSB = 360/2^ANG_W degrees.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input vertex valid.
- `in_ready` out 1: stage accepts input this cycle.
- `in_axis` in 2: 0=X, 1=Y, 2=Z, 3=bypass (translate only).
- `in_angle` in ANG_W: rotation angle, unsigned.
- `in_a1`, `in_a2`, `in_a3` in W each: vertex x, y, z, signed.
- `in_t1`, `in_t2`, `in_t3` in W each: translation, signed.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_o1`, `out_o2`, `out_o3` out W each: transformed vertex, signed, saturated.
- `out_sat` out 1: at least one component saturated for this vertex.

## Operation
- Let s=sin(θ), c=cos(θ), with θ=in_angle·2π/2^ANG_W. Table entries are round(s·2^FRAC) and round(c·2^FRAC).
- X axis: o1=a1; o2=c·a2−s·a3; o3=s·a2+c·a3.
- Y axis: o1=c·a1+s·a3; o2=a2; o3=−s·a1+c·a3.
- Z axis: o1=c·a1−s·a2; o2=s·a1+c·a2; o3=a3.
- Bypass: o=a (angle ignored).
- Translation is then added to every component.
- Arithmetic is full precision with no intermediate truncation:
  - Each product is W+FRAC+2 bits.
  - Pass-through components are formed as a<<FRAC.
  - Translation enters as t<<FRAC.
  - Sum width is W+FRAC+4.
- Rounding: add 2^(FRAC−1), then arithmetic shift right by FRAC (round half toward +∞).
- Saturation: clamp to [−2^(W−1), 2^(W−1)−1]. out_sat is the OR of the per-component clamp flags.
- Pipeline:
  - S1 registers operands, axis and table sin/cos.
  - S2 registers the six products.
  - S3 registers the sum, round and saturate results plus out_valid.
- Flow control is a global stall: en = !out_valid || out_ready. All stages advance only when en=1. in_ready = en.
- A transfer occurs on in_valid && in_ready, and likewise on out_valid && out_ready.
- Bubbles propagate as valid=0. Valid bits advance whenever en=1.
- While stalled (out_valid && !out_ready), out_* and out_sat hold stable.

## Timing
- Reset: all valid bits 0; out_valid=0, out_o1..3=0, out_sat=0; in_ready=1 on the first cycle after rst_n deasserts.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall.
- Throughput: 1 vertex/cycle while out_ready=1.
- Reset asserted mid-operation: in-flight vertices are discarded and outputs go to reset values immediately (asynchronous). No output is produced for vertices accepted before the reset.
- Input transfer and output transfer in the same cycle are legal; the pipeline shifts with no loss.
- Angle wrap: angle 2^ANG_W−1 is the step just below 360°. No special case is needed.

## Structure
- Package `gpu_xform_pkg`:
  - axis encoding constants (AXIS_X/Y/Z/BYP);
  - constant function `trig_q(idx, ANG_W, FRAC)` that builds the sin table at elaboration;
  - saturation helper function.
- Sub-module `trig_rom`: quarter-wave table of 2^(ANG_W−2)+1 entries, with quadrant folding for sin and cos. cos is taken as the sin index plus a quarter turn. Output is registered to form S1.
- Top level holds the axis mux, the S2 multipliers, the S3 adder/round/saturate logic and the stall logic.

## Test plan
All scenarios use default parameters.
- Y axis, angle 16 (90°), a=(100,5,−20), t=0 → o=(−20,5,−100), out_sat=0, 3 cycles after accept.
- X axis, angle 8 (45°, table value 181), a=(0,100,0), t=(3,0,−1) → o=(3,71,70).
- Bypass, a=(500,−500,0), t=(100,−100,7) → o=(511,−512,7), out_sat=1.
- Stream 20 random vertices with out_ready toggling pseudo-randomly → outputs match a reference model in order, none lost or duplicated, out_* stable while stalled, in_ready==(!out_valid||out_ready).
- Z axis, angle 32 (180°), a=(−512,10,1) → o1=511 (saturated), o2=−10, o3=1, out_sat=1.
- Accept 3 vertices, then pulse rst_n low for 1 cycle → out_valid=0 and outputs 0 immediately; no output appears for the flushed vertices; the next vertex appears 3 cycles after accept.
